raw_hazard_scoreboard: RTL and testbench
========================================

Name: raw_hazard_scoreboard

Overview:
- Generates the `stall` input of the read (register-fetch) stage.
- Tracks in-flight writes to each architectural register, x1..x31, with per-register counters.
- Requests a stall when the instruction presented at the read stage has a RAW or counter-overflow hazard.
- Serialises FENCE/SYSTEM instructions: drains all pending writes first, then holds off younger instructions for a fixed number of cycles.

Parameters:
- CNT_W, 2, width of each per-register in-flight counter; max count = 2^CNT_W-1.
- HOLD_CYC, 2, stall cycles forced after a serialising instruction issues; legal range 1..15.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- IR  input  32  instruction currently presented to the read stage.
- v_in  input  1  IR is valid.
- issue  input  1  read stage accepted IR this cycle (v_in & r_out).
- v_wb  input  1  writeback valid this cycle.
- WB_address  input  5  writeback destination register.
- stall  output  1  combinational stall request to the read stage.
- busy  output  1  registered; any counter nonzero.
- pending_mask  output  32  registered; bit n = counter[n]!=0; bit 0 always 0.
- err  output  1  sticky; writeback to a register with zero count, or issue while stall=1.

Behaviour:
- Decode, on IR[6:0]:
  - Writes rd (rd=IR[11:7]): LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP 0110011.
  - Uses rs1 (IR[19:15]): JALR, BRANCH 1100011, LOAD, STORE 0100011, OP-IMM, OP.
  - Uses rs2 (IR[24:20]): BRANCH, STORE, OP.
  - Serialising: FENCE 0001111, SYSTEM 1110011. Neither writes rd nor is tracked.
  - rd=x0 is never tracked. rs=x0 never hazards.
- Counters: cnt[1..31], CNT_W bits each, all 0 at reset.
  - Increment cnt[rd] on issue & writes_rd & rd!=0.
  - Decrement cnt[WB_address] on v_wb & WB_address!=0 & cnt!=0.
  - Increment and decrement of the same register in the same cycle: net unchanged.
  - v_wb to a register with cnt=0: no change, err<=1.
- Hazard terms, evaluated only when v_in=1:
  - raw = (uses_rs1 & cnt[rs1]!=0) | (uses_rs2 & cnt[rs2]!=0).
  - ovf = writes_rd & rd!=0 & cnt[rd]==max.
- FSM, states RUN, DRAIN, HOLD. Reset to RUN, hold counter 0.
  - RUN: stall = v_in & (raw | ovf | (serialising & busy)).
    - v_in & serialising & busy -> DRAIN.
    - issue & serialising & !busy -> HOLD, load hold counter with HOLD_CYC.
  - DRAIN: stall=1 while busy. When busy is 0, stall = v_in & (raw | ovf) and the state returns to RUN in that cycle's transition. If that cycle also sees issue & serialising, go to HOLD instead.
  - HOLD: stall=1. Hold counter decrements each cycle; at 1 -> RUN, so stall is high exactly HOLD_CYC cycles.
- busy and pending_mask reflect counters after the clock edge (1-cycle latency from issue/v_wb).
- err: set if issue=1 while stall=1. Cleared only by rst.
- rst mid-operation: all counters, FSM, err and hold counter cleared on the next edge. stall=0 the cycle after, unless an IR hazard exists against the cleared state (none).

Optional Feature:
- Macro SCOREBOARD_WB_BYPASS_EN. Matches the read stage forwarding WB_data when a source address equals WB_address.
- Defined: a source whose cnt==1 and which matches WB_address with v_wb=1 in the same cycle is not a RAW hazard, so stall drops that cycle.
- Undefined: the hazard is released only after the counter reaches 0 (one extra stall cycle).
- Counter update behaviour is identical in both builds.

Test Plan:
1. Reset, then issue ADDI x5,x0,1 (0x00100293), next cycle present ADD x6,x5,x5 (0x00528333) with v_in=1 -> stall=1 until v_wb with WB_address=5. Bypass build: stall=0 in the v_wb cycle. Non-bypass build: stall=0 the cycle after. pending_mask bit5 goes 1 then 0.
2. Issue three LW x7 (0x0000a383) writes, CNT_W=2 -> cnt[7]=3. Present a fourth LW x7 -> stall=1 (ovf). One v_wb to x7 -> stall=0.
3. Same-cycle issue of ADDI x9 and v_wb x9 with cnt[9]=1 -> cnt[9] stays 1, busy stays 1.
4. With cnt[3]=1, present FENCE (0x0ff0000f) -> DRAIN, stall=1. v_wb x3 -> stall=0. Issue FENCE -> HOLD, stall=1 for exactly 2 cycles, then RUN.
5. v_wb x12 with cnt[12]=0 -> err=1, counters unchanged. Assert rst -> err=0, busy=0, pending_mask=0 next cycle.
6. Instructions with rd=x0 (ADDI x0,x0,0 = 0x00000013) or rs=x0 never raise stall and never set a counter.

Source files
------------

// File: rtl/raw_hazard_scoreboard_if.sv
// rtl/raw_hazard_scoreboard_if.sv - read-stage / writeback bundle for the RAW hazard scoreboard
// master: pipeline side driving the presented instruction and writebacks; slave: the scoreboard.
interface raw_hazard_scoreboard_if;
    logic [31:0] IR;
    logic        v_in;
    logic        issue;
    logic        v_wb;
    logic [4:0]  WB_address;
    logic        stall;
    logic        busy;
    logic [31:0] pending_mask;
    logic        err;

    modport master (
        output IR,
        output v_in,
        output issue,
        output v_wb,
        output WB_address,
        input  stall,
        input  busy,
        input  pending_mask,
        input  err
    );

    modport slave (
        input  IR,
        input  v_in,
        input  issue,
        input  v_wb,
        input  WB_address,
        output stall,
        output busy,
        output pending_mask,
        output err
    );
endinterface

// File: rtl/raw_hazard_scoreboard.sv
// rtl/raw_hazard_scoreboard.sv - per-register in-flight write counters driving the read-stage stall
// Optional SCOREBOARD_WB_BYPASS_EN: a source whose last pending write is retiring this cycle does not stall.
module raw_hazard_scoreboard #(
    parameter int CNT_W    = 2,
    parameter int HOLD_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    raw_hazard_scoreboard_if.slave  sb
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       HOLD_LD  = 4'(HOLD_CYC);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [3:0]       hold_cnt, hold_next;
    logic [CNT_W-1:0] cnt      [32];
    logic [CNT_W-1:0] cnt_next [32];
    logic [31:0]      mask_q, mask_next;
    logic             busy_q;
    logic             err_q, err_next;
    logic             stall_c;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       writes_rd, uses_rs1, uses_rs2, serialising;
    logic       inc_en, wb_hit, wb_cnt_zero;
    logic       raw, ovf, raw1, raw2, byp1, byp2;
    logic       unused_ir;

    assign opcode = sb.IR[6:0];
    assign rd     = sb.IR[11:7];
    assign rs1    = sb.IR[19:15];
    assign rs2    = sb.IR[24:20];
    assign unused_ir = ^{sb.IR[31:25], sb.IR[14:12]};

    always_comb begin
        writes_rd   = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        serialising = 1'b0;
        unique case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
            end
            OP_OP: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: serialising = 1'b1;
            default: ;
        endcase
    end

    assign inc_en      = sb.issue && writes_rd && (rd != 5'd0);
    assign wb_cnt_zero = (cnt[sb.WB_address] == '0);
    assign wb_hit      = sb.v_wb && (sb.WB_address != 5'd0) && !wb_cnt_zero;

    // A write retiring on the bus this cycle is forwarded by the read stage, so its
    // last outstanding instance no longer blocks the consumer.
`ifdef SCOREBOARD_WB_BYPASS_EN
    assign byp1 = sb.v_wb && (sb.WB_address == rs1) && (cnt[rs1] == CNT_ONE);
    assign byp2 = sb.v_wb && (sb.WB_address == rs2) && (cnt[rs2] == CNT_ONE);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign raw1 = uses_rs1 && (rs1 != 5'd0) && (cnt[rs1] != '0) && !byp1;
    assign raw2 = uses_rs2 && (rs2 != 5'd0) && (cnt[rs2] != '0) && !byp2;
    assign raw  = sb.v_in && (raw1 || raw2);
    assign ovf  = sb.v_in && writes_rd && (rd != 5'd0) && (cnt[rd] == CNT_MAX);

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_next[i] = cnt[i];
        end
        for (int i = 1; i < 32; i++) begin
            logic inc_i, dec_i;
            inc_i = inc_en && (rd == 5'(i));
            dec_i = wb_hit && (sb.WB_address == 5'(i));
            if (inc_i && !dec_i && (cnt[i] != CNT_MAX)) begin
                cnt_next[i] = cnt[i] + CNT_ONE;
            end else if (dec_i && !inc_i) begin
                cnt_next[i] = cnt[i] - CNT_ONE;
            end
        end
        cnt_next[0] = '0;
    end

    always_comb begin
        mask_next = '0;
        for (int i = 1; i < 32; i++) begin
            mask_next[i] = (cnt_next[i] != '0);
        end
    end

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        stall_c    = 1'b0;
        unique case (state)
            RUN: begin
                stall_c = raw || ovf || (sb.v_in && serialising && busy_q);
                if (sb.v_in && serialising && busy_q) begin
                    state_next = DRAIN;
                end else if (sb.issue && serialising && !busy_q) begin
                    state_next = HOLD;
                    hold_next  = HOLD_LD;
                end
            end
            DRAIN: begin
                if (busy_q) begin
                    stall_c = 1'b1;
                end else begin
                    stall_c = raw || ovf;
                    if (sb.issue && serialising) begin
                        state_next = HOLD;
                        hold_next  = HOLD_LD;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            HOLD: begin
                stall_c = 1'b1;
                if (hold_cnt <= 4'd1) begin
                    state_next = RUN;
                    hold_next  = 4'd0;
                end else begin
                    hold_next = hold_cnt - 4'd1;
                end
            end
            default: begin
                state_next = RUN;
                hold_next  = 4'd0;
            end
        endcase
    end

    assign err_next = err_q
                    || (sb.issue && stall_c)
                    || (sb.v_wb && wb_cnt_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            hold_cnt <= 4'd0;
            mask_q   <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            mask_q   <= mask_next;
            busy_q   <= |mask_next;
            err_q    <= err_next;
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign sb.stall        = stall_c;
    assign sb.busy         = busy_q;
    assign sb.pending_mask = mask_q;
    assign sb.err          = err_q;
endmodule

// File: tb/tb_raw_hazard_scoreboard.sv
// tb/tb_raw_hazard_scoreboard.sv - directed-vector scoreboard bench for raw_hazard_scoreboard
module tb_raw_hazard_scoreboard;
    localparam logic [31:0] ADDI5 = 32'h00100293;
    localparam logic [31:0] ADD6  = 32'h00528333;
    localparam logic [31:0] LW7   = 32'h0000a383;
    localparam logic [31:0] ADDI9 = 32'h00100493;
    localparam logic [31:0] ADDI3 = 32'h00100193;
    localparam logic [31:0] FENCE = 32'h0ff0000f;
    localparam logic [31:0] NOP0  = 32'h00000013;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam int BYP_STALL = 0;
`else
    localparam int BYP_STALL = 1;
`endif

    typedef struct {
        string  nm;
        int     es;
        int     eb;
        longint em;
        int     ee;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     checks = 0;
    int     errors = 0;
    exp_t   exp_q[$];

    raw_hazard_scoreboard_if bus ();

    raw_hazard_scoreboard #(.CNT_W(2), .HOLD_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog sim time exceeded got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Monitor: one expectation per cycle, compared mid-cycle on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.es >= 0) begin
                checks++;
                if (bus.stall !== e.es[0]) begin
                    errors++;
                    $display("FAIL %s stall got %0b want %0d", e.nm, bus.stall, e.es);
                end
            end
            if (e.eb >= 0) begin
                checks++;
                if (bus.busy !== e.eb[0]) begin
                    errors++;
                    $display("FAIL %s busy got %0b want %0d", e.nm, bus.busy, e.eb);
                end
            end
            if (e.em >= 0) begin
                checks++;
                if (bus.pending_mask !== e.em[31:0]) begin
                    errors++;
                    $display("FAIL %s pending_mask got %h want %h", e.nm, bus.pending_mask, e.em[31:0]);
                end
            end
            if (e.ee >= 0) begin
                checks++;
                if (bus.err !== e.ee[0]) begin
                    errors++;
                    $display("FAIL %s err got %0b want %0d", e.nm, bus.err, e.ee);
                end
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic [31:0] ir,
                        input logic vin, input logic iss, input logic vwb,
                        input logic [4:0] wba, input int es, input int eb,
                        input longint em, input int ee);
        @(posedge clk);
        #1;
        rst            = r;
        bus.IR         = ir;
        bus.v_in       = vin;
        bus.issue      = iss;
        bus.v_wb       = vwb;
        bus.WB_address = wba;
        exp_q.push_back('{nm, es, eb, em, ee});
    endtask

    initial begin
        bus.IR = '0; bus.v_in = 1'b0; bus.issue = 1'b0;
        bus.v_wb = 1'b0; bus.WB_address = '0;
        repeat (3) @(posedge clk);

        //    name              rst ir     vin iss wb  wba  stall busy mask  err
        step("reset",           0, 32'h0, 0, 0, 0, 5'd0,  0, 0, 0,     0);

        step("t1_issue_addi",   0, ADDI5, 1, 1, 0, 5'd0,  0, 0, 0,     0);
        step("t1_raw_a",        0, ADD6,  1, 0, 0, 5'd0,  1, 1, 'h20, -1);
        step("t1_raw_b",        0, ADD6,  1, 0, 0, 5'd0,  1, 1, 'h20, -1);
        step("t1_wb_cycle",     0, ADD6,  1, 0, 1, 5'd5,  BYP_STALL, 1, 'h20, -1);
        step("t1_released",     0, ADD6,  1, 0, 0, 5'd0,  0, 0, 0,     0);

        step("t2_lw_a",         0, LW7,   1, 1, 0, 5'd0,  0, 0, 0,    -1);
        step("t2_lw_b",         0, LW7,   1, 1, 0, 5'd0,  0, 1, 'h80, -1);
        step("t2_lw_c",         0, LW7,   1, 1, 0, 5'd0,  0, 1, 'h80, -1);
        step("t2_ovf",          0, LW7,   1, 0, 0, 5'd0,  1, 1, 'h80, -1);
        step("t2_ovf_wb",       0, LW7,   1, 0, 1, 5'd7,  1, 1, 'h80, -1);
        step("t2_ovf_clear",    0, LW7,   1, 0, 1, 5'd7,  0, 1, 'h80, -1);
        step("t2_drain",        0, 32'h0, 0, 0, 1, 5'd7,  0, 1, 'h80, -1);
        step("t2_empty",        0, 32'h0, 0, 0, 0, 5'd0,  0, 0, 0,     0);

        step("t3_addi9",        0, ADDI9, 1, 1, 0, 5'd0,  0, 0, 0,    -1);
        step("t3_same_cycle",   0, ADDI9, 1, 1, 1, 5'd9,  0, 1, 'h200,-1);
        step("t3_net_zero",     0, 32'h0, 0, 0, 0, 5'd0,  0, 1, 'h200, 0);
        step("t3_wb9",          0, 32'h0, 0, 0, 1, 5'd9,  0, 1, 'h200,-1);
        step("t3_empty",        0, 32'h0, 0, 0, 0, 5'd0,  0, 0, 0,     0);

        step("t4_addi3",        0, ADDI3, 1, 1, 0, 5'd0,  0, 0, 0,    -1);
        step("t4_fence_busy",   0, FENCE, 1, 0, 0, 5'd0,  1, 1, 'h8,  -1);
        step("t4_drain_wb",     0, FENCE, 1, 0, 1, 5'd3,  1, 1, 'h8,  -1);
        step("t4_fence_issue",  0, FENCE, 1, 1, 0, 5'd0,  0, 0, 0,    -1);
        step("t4_hold_1",       0, NOP0,  1, 0, 0, 5'd0,  1, -1, -1,  -1);
        step("t4_hold_2",       0, NOP0,  1, 0, 0, 5'd0,  1, -1, -1,  -1);
        step("t4_run",          0, NOP0,  1, 0, 0, 5'd0,  0, 0, 0,     0);
        step("t4_fence_idle",   0, FENCE, 1, 1, 0, 5'd0,  0, 0, 0,    -1);
        step("t4_hold_a",       0, 32'h0, 0, 0, 0, 5'd0,  1, -1, -1,  -1);
        step("t4_hold_b",       0, 32'h0, 0, 0, 0, 5'd0,  1, -1, -1,  -1);
        step("t4_run_b",        0, 32'h0, 0, 0, 0, 5'd0,  0, 0, 0,     0);

        step("t6_x0_a",         0, NOP0,  1, 1, 0, 5'd0,  0, 0, 0,    -1);
        step("t6_x0_b",         0, NOP0,  1, 1, 0, 5'd0,  0, 0, 0,    -1);
        step("t6_x0_c",         0, 32'h0, 0, 0, 0, 5'd0,  0, 0, 0,     0);

        step("t5_wb12",         0, ADDI5, 1, 1, 1, 5'd12, 0, 0, 0,     0);
        step("t5_err",          0, 32'h0, 0, 0, 0, 5'd0,  0, 1, 'h20,  1);
        step("t5_rst_assert",   1, 32'h0, 0, 0, 0, 5'd0,  0, 1, 'h20,  1);
        step("t5_rst_done",     0, 32'h0, 0, 0, 0, 5'd0,  0, 0, 0,     0);

        step("te_fence",        0, FENCE, 1, 1, 0, 5'd0,  0, 0, 0,     0);
        step("te_issue_stall",  0, NOP0,  1, 1, 0, 5'd0,  1, -1, -1,   0);
        step("te_err",          0, 32'h0, 0, 0, 0, 5'd0,  1, 0, 0,     1);
        step("te_run",          0, 32'h0, 0, 0, 0, 5'd0,  0, 0, 0,     1);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain leftover got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
